c1_bus_arbiter: RTL and testbench

- Shares the single cache-side C1/A1/D1 bus between NREQ CPU-side requesters.
- Grants round-robin and sequences the multi-cycle C1 command/address/data protocol for the winner.
- Collects the cache's C1_RESPONSE and returns read data to the owning requester.
- Sits between the CPU cores and the cache; the tri-state bus drivers live outside the block.

---
 rtl/c1_bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_c1_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1_bus_arbiter.sv
// Round-robin owner of the shared cache-side C1/A1/D1 bus: grants one CPU requester,
// sequences the C1 command/address/data phases and returns the cache response.
// Optional response watchdog is built when RESPONSE_TIMEOUT_EN is defined.
module c1_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_cmd,
    input  logic [19*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [2:0]           c1_out,
    output logic                 c1_oe,
    output logic [14:0]          a1_out,
    output logic [15:0]          d1_out,
    output logic                 d1_oe,
    input  logic [2:0]           c1_in,
    input  logic [15:0]          d1_in,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] CMD_READ8   = 3'd1;
    localparam logic [2:0] CMD_READ16  = 3'd2;
    localparam logic [2:0] CMD_READ32  = 3'd3;
    localparam logic [2:0] CMD_WRITE8  = 3'd5;
    localparam logic [2:0] CMD_WRITE32 = 3'd7;
    localparam logic [2:0] C1_RESPONSE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR1, ST_ADDR2, ST_DATA2, ST_WAIT_RSP, ST_RSP2, ST_DONE
    } state_t;

    state_t        state_r, state_nx_s;
    logic [IW-1:0] rr_r, owner_r, win_s, off_s;
    logic [NREQ-1:0] elig_s, rot_s;
    logic          win_found_s;
    logic [2:0]    cmd_r;
    logic [18:0]   addr_r;
    logic [31:0]   wdata_r, rdata_r;
    logic          err_r, rsp_seen_s, is_write_s, timeout_s;
    logic [2:0]    cmd_a_s   [NREQ];
    logic [18:0]   addr_a_s  [NREQ];
    logic [31:0]   wdata_a_s [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign cmd_a_s[g]   = req_cmd[3*g +: 3];
        assign addr_a_s[g]  = req_addr[19*g +: 19];
        assign wdata_a_s[g] = req_wdata[32*g +: 32];
        assign elig_s[g]    = req_valid[g] && (req_cmd[3*g +: 3] != 3'd0);
    end

    assign rsp_seen_s = (c1_in == C1_RESPONSE);
    assign is_write_s = cmd_r[2] && (cmd_r[1:0] != 2'd0);
    assign busy       = (state_r != ST_IDLE);
    assign rsp_rdata  = rdata_r;
    assign rsp_err    = err_r;

`ifdef RESPONSE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt_r;

    // Watchdog: zero on entry to WAIT_RSP, counts through WAIT_RSP and RSP2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_RSP) || (state_r == ST_RSP2)) begin
            wd_cnt_r <= wd_cnt_r + CW'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end
    assign timeout_s = (wd_cnt_r >= CW'(TIMEOUT - 1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 0);
    assign timeout_s        = 1'b0;
`endif

    // Round-robin pick: rotate eligibility so the rr pointer sits at bit 0.
    always_comb begin
        rot_s       = NREQ'({elig_s, elig_s} >> rr_r);
        win_found_s = |rot_s;
        off_s       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? IW'(k) : off_s;
        end
        win_s = IW'((int'(rr_r) + int'(off_s)) % NREQ);
    end

    // Bus phase decode and next-state selection.
    always_comb begin
        state_nx_s = state_r;
        req_ready  = '0;
        rsp_valid  = '0;
        c1_oe      = 1'b0;
        c1_out     = 3'd0;
        a1_out     = 15'd0;
        d1_oe      = 1'b0;
        d1_out     = 16'd0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s && !reset) begin
                    req_ready[win_s] = 1'b1;
                    state_nx_s       = ST_ADDR1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR1: begin
                c1_oe      = 1'b1;
                c1_out     = cmd_r;
                a1_out     = addr_r[18:4];
                state_nx_s = ST_ADDR2;
            end
            ST_ADDR2: begin
                c1_oe  = 1'b1;
                c1_out = cmd_r;
                a1_out = {11'd0, addr_r[3:0]};
                if (is_write_s) begin
                    d1_oe  = 1'b1;
                    d1_out = (cmd_r == CMD_WRITE8) ? {8'd0, wdata_r[7:0]} : wdata_r[15:0];
                end else begin
                    d1_oe = 1'b0;
                end
                state_nx_s = (cmd_r == CMD_WRITE32) ? ST_DATA2 : ST_WAIT_RSP;
            end
            ST_DATA2: begin
                c1_oe      = 1'b1;
                c1_out     = cmd_r;
                d1_oe      = 1'b1;
                d1_out     = wdata_r[31:16];
                state_nx_s = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (rsp_seen_s) begin
                    state_nx_s = (cmd_r == CMD_READ32) ? ST_RSP2 : ST_DONE;
                end else if (timeout_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WAIT_RSP;
                end
            end
            ST_RSP2: begin
                if (rsp_seen_s || timeout_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RSP2;
                end
            end
            ST_DONE: begin
                rsp_valid[owner_r] = 1'b1;
                state_nx_s         = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant capture and response assembly; a response beats a same-cycle timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_r    <= '0;
            owner_r <= '0;
            cmd_r   <= 3'd0;
            addr_r  <= 19'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        owner_r <= win_s;
                        rr_r    <= IW'((int'(win_s) + 1) % NREQ);
                        cmd_r   <= cmd_a_s[win_s];
                        addr_r  <= addr_a_s[win_s];
                        wdata_r <= wdata_a_s[win_s];
                        rdata_r <= 32'd0;
                        err_r   <= 1'b0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_seen_s) begin
                        case (cmd_r)
                            CMD_READ8:  rdata_r <= {24'd0, d1_in[7:0]};
                            CMD_READ16: rdata_r <= {16'd0, d1_in};
                            CMD_READ32: rdata_r <= {16'd0, d1_in};
                            default:    rdata_r <= 32'd0;
                        endcase
                    end else if (timeout_s) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b1;
                    end
                end
                ST_RSP2: begin
                    if (rsp_seen_s) begin
                        rdata_r[31:16] <= d1_in;
                    end else if (timeout_s) begin
                        rdata_r <= 32'd0;
                        err_r   <= 1'b1;
                    end
                end
                default: begin
                    rdata_r <= rdata_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Bench for c1_bus_arbiter: directed scenarios plus randomized transactions, each
// checked cycle by cycle against a transaction-level model of grant order and bus phases.
module tb_c1_bus_arbiter;
    localparam int NREQ = 2;
    localparam int TO   = 8;
`ifdef RESPONSE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [3*NREQ-1:0]  req_cmd = '0;
    logic [19*NREQ-1:0] req_addr = '0;
    logic [32*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [2:0]         c1_out;
    logic               c1_oe;
    logic [14:0]        a1_out;
    logic [15:0]        d1_out;
    logic               d1_oe;
    logic [2:0]         c1_in = 3'd0;
    logic [15:0]        d1_in = 16'd0;
    logic               busy;

    int total = 0;
    int bad = 0;
    int m_rr = 0;
    logic [NREQ-1:0] last_ready;
    logic [31:0]     last_rdata;

    always #5 clk = ~clk;

    c1_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .c1_out(c1_out), .c1_oe(c1_oe), .a1_out(a1_out), .d1_out(d1_out), .d1_oe(d1_oe),
        .c1_in(c1_in), .d1_in(d1_in), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] c, input logic [18:0] a, input logic [31:0] wd);
        req_cmd[3*r +: 3]    = c;
        req_addr[19*r +: 19] = a;
        req_wdata[32*r +: 32] = wd;
    endtask

    task automatic do_accept(input logic [NREQ-1:0] vm, output int w);
        logic [NREQ-1:0] oh;
        cyc();
        req_valid = vm;
        c1_in = 3'($urandom_range(0, 7));
        d1_in = 16'($urandom);
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (w < 0 && vm[i] && req_cmd[3*i +: 3] != 3'd0) w = i;
        end
        oh = '0;
        if (w >= 0) begin
            oh[w] = 1'b1;
            m_rr = (w + 1) % NREQ;
        end
        last_ready = req_ready;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, oh);
        chk("idle_c1_oe", c1_oe, 0);
    endtask

    task automatic do_drive(input int w);
        logic [2:0] cmd; logic [18:0] addr; logic [31:0] wd; bit wr; int nph;
        cmd  = req_cmd[3*w +: 3];
        addr = req_addr[19*w +: 19];
        wd   = req_wdata[32*w +: 32];
        wr   = (cmd >= 3'd5);
        nph  = (cmd == 3'd7) ? 3 : 2;
        for (int p = 0; p < nph; p++) begin
            cyc();
            c1_in = 3'($urandom_range(0, 7));
            d1_in = 16'($urandom);
            #1;
            chk($sformatf("ph%0d_busy", p), busy, 1);
            chk($sformatf("ph%0d_ready", p), req_ready, 0);
            chk($sformatf("ph%0d_rspv", p), rsp_valid, 0);
            chk($sformatf("ph%0d_c1_oe", p), c1_oe, 1);
            chk($sformatf("ph%0d_c1_out", p), c1_out, cmd);
            if (p == 0) begin
                chk("addr1_a1", a1_out, addr[18:4]);
                chk("addr1_d1_oe", d1_oe, 0);
            end else if (p == 1) begin
                chk("addr2_a1", a1_out, {11'd0, addr[3:0]});
                chk("addr2_d1_oe", d1_oe, wr);
                if (wr) chk("addr2_d1", d1_out, (cmd == 3'd5) ? {8'd0, wd[7:0]} : wd[15:0]);
            end else begin
                chk("data2_d1_oe", d1_oe, 1);
                chk("data2_d1", d1_out, wd[31:16]);
            end
        end
    endtask

    task automatic do_wait(input int w, input int g1, input int g2, input logic [15:0] w0,
                           input logic [15:0] w1, output bit err, output logic [31:0] exp_rd);
        logic [2:0] cmd; int k; bit got0, done, resp;
        cmd = req_cmd[3*w +: 3];
        k = 0; got0 = 0; done = 0; err = 0;
        while (!done) begin
            resp = got0 ? (k == g1 + 1 + g2) : (k == g1);
            cyc();
            c1_in = resp ? 3'd7 : 3'($urandom_range(0, 6));
            d1_in = resp ? (got0 ? w1 : w0) : 16'($urandom);
            #1;
            chk("wait_busy", busy, 1);
            chk("wait_c1_oe", c1_oe, 0);
            chk("wait_d1_oe", d1_oe, 0);
            chk("wait_rspv", rsp_valid, 0);
            if (resp && cmd == 3'd3 && !got0) got0 = 1;
            else if (resp) done = 1;
            else if (TO_EN && k >= TO - 1) begin done = 1; err = 1; end
            k++;
        end
        case (cmd)
            3'd1:    exp_rd = {24'd0, w0[7:0]};
            3'd2:    exp_rd = {16'd0, w0};
            3'd3:    exp_rd = {w1, w0};
            default: exp_rd = 32'd0;
        endcase
        if (err) exp_rd = 32'd0;
    endtask

    task automatic do_done(input int w, input bit err, input logic [31:0] exp_rd);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[w] = 1'b1;
        cyc();
        c1_in = 3'($urandom_range(0, 7));
        #1;
        chk("done_rspv", rsp_valid, oh);
        chk("done_rdata", rsp_rdata, exp_rd);
        chk("done_err", rsp_err, err);
        chk("done_busy", busy, 1);
        chk("done_c1_oe", c1_oe, 0);
        chk("done_ready", req_ready, 0);
        last_rdata = rsp_rdata;
    endtask

    task automatic txn(input logic [NREQ-1:0] vm, input int g1, input int g2,
                       input logic [15:0] w0, input logic [15:0] w1);
        int w; bit err; logic [31:0] er;
        do_accept(vm, w);
        if (w >= 0) begin
            do_drive(w);
            do_wait(w, g1, g2, w0, w1, err, er);
            do_done(w, err, er);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state, with requests pending that must not be acknowledged
        set_req(0, 3'd2, 19'h00100, 32'h0);
        set_req(1, 3'd2, 19'h00200, 32'h0);
        req_valid = 2'b11;
        cyc();
        chk("rst_c1_oe", c1_oe, 0);   chk("rst_d1_oe", d1_oe, 0);
        chk("rst_c1_out", c1_out, 0); chk("rst_a1", a1_out, 0);
        chk("rst_d1", d1_out, 0);     chk("rst_ready", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0); chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);   chk("rst_busy", busy, 0);
        reset = 1'b0;
        req_valid = '0;

        // READ8 from req 0
        set_req(0, 3'd1, 19'h00539, 32'h0);
        txn(2'b01, 0, 0, 16'h12E4, 16'h0);
        chk("read8_rdata", last_rdata, 32'h000000E4);

        // WRITE32 from req 1
        set_req(1, 3'd7, 19'h7FFF0, 32'hDEADBEEF);
        txn(2'b10, 0, 0, 16'hAAAA, 16'h0);
        chk("write32_rdata", last_rdata, 32'h0);

        // READ32 with a 3-cycle gap between response words
        set_req(0, 3'd3, 19'h01234, 32'h0);
        txn(2'b01, 0, 3, 16'h5678, 16'h1234);
        chk("read32_rdata", last_rdata, 32'h12345678);

        // Both requesters continuously valid: strict alternation, req 1 first
        set_req(0, 3'd2, 19'h00AA0, 32'h0);
        set_req(1, 3'd2, 19'h00BB0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, $urandom_range(0, 2), 0, 16'($urandom), 16'h0);
            chk("rr_seq", last_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // NOP requester never wins
        set_req(1, 3'd0, 19'h00CC0, 32'h0);
        set_req(0, 3'd4, 19'h00DD0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            txn(2'b11, 0, 0, 16'h0, 16'h0);
            chk("nop_skip", last_ready, 2'b01);
        end
        do_accept(2'b10, w);
        cyc();
        chk("nop_only_busy", busy, 0);

        // Reset while waiting for the response
        set_req(0, 3'd2, 19'h00EE0, 32'h0);
        do_accept(2'b01, w);
        do_drive(0);
        cyc();
        c1_in = 3'd0;
        #1;
        chk("prerst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);     chk("midrst_c1_oe", c1_oe, 0);
        chk("midrst_d1_oe", d1_oe, 0);   chk("midrst_ready", req_ready, 0);
        cyc();
        reset = 1'b0;
        req_valid = '0;
        m_rr = 0;
        for (int i = 0; i < 3; i++) begin
            c1_in = 3'd7;
            d1_in = 16'hFFFF;
            #1;
            chk("postrst_rspv", rsp_valid, 0);
            chk("postrst_busy", busy, 0);
            cyc();
        end
        set_req(1, 3'd2, 19'h00FF0, 32'h0);
        txn(2'b11, 0, 0, 16'h4321, 16'h0);
        chk("postrst_grant", last_ready, 2'b01);

`ifdef RESPONSE_TIMEOUT_EN
        // Silent cache: watchdog completes with an error
        set_req(0, 3'd1, 19'h00123, 32'h0);
        txn(2'b01, 30, 0, 16'h00FF, 16'h0);
        chk("to_rdata", last_rdata, 32'h0);
        set_req(1, 3'd3, 19'h00456, 32'h0);
        txn(2'b10, 2, 30, 16'h1111, 16'h2222);
        chk("to_r32_rdata", last_rdata, 32'h0);
`endif

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < NREQ; r++)
                set_req(r, 3'($urandom_range(0, 7)), 19'($urandom), $urandom);
            txn(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
